// File: rtl/in_module_pkg.sv
// Shared definitions for the IN-instruction input path: FSM states and sizing helpers.
package in_module_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    WAIT_PRESS   = 2'd2,
    DELIVER      = 2'd3
  } in_state_t;

  localparam int DATA_W_DEFAULT          = 16;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  // Debounce counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int db_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/in_debouncer.sv
// Confirm-button conditioning: synchroniser chain plus stable-count debounce, with a registered rise pulse.
module in_debouncer
  import in_module_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic btn_db,
  output logic rise
);

  localparam int                CNT_W    = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   btn_db_r;
  logic                   rise_r;
  logic                   btn_sync_s;

  assign btn_sync_s = sync_r[SYNC_STAGES-1];

  // Metastability chain for the raw asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive samples that disagree with the current one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      btn_db_r <= 1'b0;
      rise_r   <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      if (btn_sync_s == btn_db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r    <= '0;
        btn_db_r <= btn_sync_s;
        rise_r   <= btn_sync_s;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign btn_db = btn_db_r;
  assign rise   = rise_r;

endmodule

// File: rtl/in_module.sv
// Services the CPU IN instruction: stalls the PC until a debounced confirm press, then delivers the switches.
// Optional timeout delivery (in_data=0, in_timeout=1) is built in when IN_TIMEOUT_EN is defined.
module in_module
  import in_module_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef IN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 32'd16777216
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] switches,
  input  logic              confirm_btn,
  input  logic              cu_inReq,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              in_stall
`ifdef IN_TIMEOUT_EN
  , output logic            in_timeout
`endif
);

  in_state_t         state_r;
  logic [DATA_W-1:0] in_data_r;
  logic              in_valid_r;
  logic [DATA_W-1:0] sw_sync_r [SYNC_STAGES];
  logic              btn_db_s;
  logic              rise_s;
  logic              tmo_hit_s;

  in_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (clock),
    .reset (reset),
    .btn   (confirm_btn),
    .btn_db(btn_db_s),
    .rise  (rise_s)
  );

  // Switch bus synchroniser; the last stage is what gets captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= '0;
      end
    end else begin
      sw_sync_r[0] <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= sw_sync_r[i-1];
      end
    end
  end

`ifdef IN_TIMEOUT_EN
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             in_timeout_r;
  logic             waiting_s;

  assign waiting_s = (state_r == WAIT_PRESS) && cu_inReq && !rise_s;
  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

  // Counts cycles spent waiting for a press; cleared whenever WAIT_PRESS is left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r    <= '0;
      in_timeout_r <= 1'b0;
    end else begin
      in_timeout_r <= waiting_s && tmo_hit_s;
      if (waiting_s && !tmo_hit_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      end else begin
        tmo_cnt_r <= '0;
      end
    end
  end

  assign in_timeout = in_timeout_r;
`else
  assign tmo_hit_s = 1'b0;
`endif

  // IN handshake FSM; a press already held when the IN arrives must be released first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      in_data_r  <= '0;
      in_valid_r <= 1'b0;
    end else begin
      in_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cu_inReq) begin
            state_r <= btn_db_s ? WAIT_RELEASE : WAIT_PRESS;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (!cu_inReq) begin
            state_r <= IDLE;
          end else if (!btn_db_s) begin
            state_r <= WAIT_PRESS;
          end else begin
            state_r <= WAIT_RELEASE;
          end
        end
        WAIT_PRESS: begin
          if (!cu_inReq) begin
            state_r <= IDLE;
          end else if (rise_s) begin
            in_data_r  <= sw_sync_r[SYNC_STAGES-1];
            in_valid_r <= 1'b1;
            state_r    <= DELIVER;
          end else if (tmo_hit_s) begin
            in_data_r  <= '0;
            in_valid_r <= 1'b1;
            state_r    <= DELIVER;
          end else begin
            state_r <= WAIT_PRESS;
          end
        end
        DELIVER: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_data  = in_data_r;
  assign in_valid = in_valid_r;
  assign in_stall = cu_inReq & (state_r != DELIVER);

endmodule

// File: tb/tb_in_module.sv
// Self-checking bench for in_module: vector table, hand sequences and randomized IN transactions.
`timescale 1ns/1ps
module tb_in_module;

  localparam int DW = 16;

  logic          clock       = 1'b0;
  logic          reset       = 1'b0;
  logic [DW-1:0] switches    = '0;
  logic          confirm_btn = 1'b0;
  logic          cu_inReq    = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_stall;
`ifdef IN_TIMEOUT_EN
  logic          in_timeout;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_data = '0;   // last value the model says was delivered
  bit prev_valid = 1'b0;

  in_module #(
    .DATA_W         (DW),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
`ifdef IN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .switches   (switches),
    .confirm_btn(confirm_btn),
    .cu_inReq   (cu_inReq),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_stall   (in_stall)
`ifdef IN_TIMEOUT_EN
    , .in_timeout(in_timeout)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // in_valid is a single-cycle strobe and never coincides with a stall.
  always @(negedge clock) begin
    if (reset) begin
      check("valid_one_cycle", {31'd0, in_valid & prev_valid}, 32'd0);
      check("valid_without_stall", {31'd0, in_valid & in_stall}, 32'd0);
`ifdef IN_TIMEOUT_EN
      check("timeout_implies_valid", {31'd0, in_timeout & ~in_valid}, 32'd0);
`endif
    end
    prev_valid = in_valid;
  end

  task automatic wait_valid(input int maxc, output bit seen, output bit stall_bad, output int ncyc);
    seen = 1'b0; stall_bad = 1'b0; ncyc = 0;
    while (!seen && ncyc < maxc) begin
      tick();
      ncyc++;
      if (in_valid) seen = 1'b1;
      else if (!in_stall) stall_bad = 1'b1;
    end
  endtask

  task automatic idle_count(input int n, inout int nvalid);
    for (int i = 0; i < n; i++) begin
      tick();
      if (in_valid) nvalid++;
    end
  endtask

  // One complete IN: request, optional bounce, settle high, expect exactly one delivery of exp.
  task automatic run_in(input logic [DW-1:0] sw, input int bounce, input logic [DW-1:0] exp, input string tag);
    bit seen, stall_bad;
    int ncyc, nvalid;
    nvalid = 0;
    switches = sw;
    cu_inReq = 1'b1;
    #1;
    check({tag, "_stall_same_cycle"}, {31'd0, in_stall}, 32'd1);
    for (int i = 0; i < bounce; i++) begin
      confirm_btn = ((i / 2) % 2) == 0;
      tick();
      if (in_valid) nvalid++;
    end
    check({tag, "_no_valid_while_bouncing"}, nvalid, 32'd0);
    confirm_btn = 1'b1;
    wait_valid(40, seen, stall_bad, ncyc);
    check({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_data"}, {16'd0, in_data}, {16'd0, exp});
    check({tag, "_stall_low_at_valid"}, {31'd0, in_stall}, 32'd0);
    check({tag, "_stalled_before_valid"}, {31'd0, stall_bad}, 32'd0);
`ifdef IN_TIMEOUT_EN
    check({tag, "_no_timeout_flag"}, {31'd0, in_timeout}, 32'd0);
`endif
    model_data = exp;
    cu_inReq = 1'b0;
    nvalid = 0;
    idle_count(2, nvalid);
    confirm_btn = 1'b0;
    idle_count(12, nvalid);
    check({tag, "_no_extra_valid"}, nvalid, 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] sw;
    int            bounce;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit   seen, stall_bad;
    int   ncyc, nvalid;

    vecs[0] = '{16'hA5C3, 0,  16'hA5C3};
    vecs[1] = '{16'h1234, 20, 16'h1234};
    vecs[2] = '{16'hFFFF, 6,  16'hFFFF};
    vecs[3] = '{16'h8001, 2,  16'h8001};

    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, in_valid}, 32'd0);
    check("rst_data", {16'd0, in_data}, 32'd0);
    check("rst_stall_idle", {31'd0, in_stall}, 32'd0);
    cu_inReq = 1'b1; #1;
    check("rst_stall_follows_req", {31'd0, in_stall}, 32'd1);
    cu_inReq = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();

    // Vector table: basic IN and bounce cases
    for (int v = 0; v < 4; v++) begin
      run_in(vecs[v].sw, vecs[v].bounce, vecs[v].exp_data, $sformatf("vec%0d", v));
    end

    // Back-to-back IN with the button held through the first delivery
    switches = 16'h1111; cu_inReq = 1'b1; confirm_btn = 1'b1;
    wait_valid(40, seen, stall_bad, ncyc);
    check("b2b_first_valid", {31'd0, seen}, 32'd1);
    check("b2b_first_data", {16'd0, in_data}, 32'h1111);
    switches = 16'h0042;
    nvalid = 0; stall_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_valid) nvalid++;
      if (!in_stall) stall_bad = 1'b1;
    end
    confirm_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (in_valid) nvalid++;
      if (!in_stall) stall_bad = 1'b1;
    end
    check("b2b_held_press_not_reused", nvalid, 32'd0);
    check("b2b_stalled_until_press", {31'd0, stall_bad}, 32'd0);
    confirm_btn = 1'b1;
    wait_valid(40, seen, stall_bad, ncyc);
    check("b2b_second_valid", {31'd0, seen}, 32'd1);
    check("b2b_second_data", {16'd0, in_data}, 32'h0042);
    model_data = 16'h0042;
    cu_inReq = 1'b0; tick(); confirm_btn = 1'b0;
    nvalid = 0; idle_count(12, nvalid);

    // Abort in WAIT_PRESS, then a press with no request pending
    cu_inReq = 1'b1; tick(); tick(); tick();
    cu_inReq = 1'b0; switches = 16'hBEEF; tick();
    confirm_btn = 1'b1; nvalid = 0;
    idle_count(15, nvalid);
    confirm_btn = 1'b0;
    idle_count(12, nvalid);
    check("abort_no_valid", nvalid, 32'd0);
    check("abort_data_kept", {16'd0, in_data}, {16'd0, model_data});

    // Reset asserted in the DELIVER cycle
    switches = 16'h5A5A; cu_inReq = 1'b1; confirm_btn = 1'b1;
    wait_valid(40, seen, stall_bad, ncyc);
    check("rstdel_valid_seen", {31'd0, seen}, 32'd1);
    reset = 1'b0; #1;
    check("rstdel_valid_cleared", {31'd0, in_valid}, 32'd0);
    check("rstdel_data_cleared", {16'd0, in_data}, 32'd0);
    check("rstdel_stall_eq_req", {31'd0, in_stall}, 32'd1);
    model_data = '0;
    cu_inReq = 1'b0; confirm_btn = 1'b0;
    tick(); tick();
    reset = 1'b1;
    nvalid = 0; idle_count(10, nvalid);
    check("rstdel_no_valid_after", nvalid, 32'd0);

    // Randomized transactions against the transaction-level model
    for (int it = 0; it < 24; it++) begin
      logic [DW-1:0] sw;
      int bounce;
      sw = DW'($urandom);
      bounce = 2 * $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) begin
        cu_inReq = 1'b1;
        idle_count($urandom_range(1, 5), nvalid);
        cu_inReq = 1'b0; switches = sw; tick();
        confirm_btn = 1'b1; nvalid = 0;
        idle_count(12, nvalid);
        confirm_btn = 1'b0;
        idle_count(12, nvalid);
        check($sformatf("rand%0d_abort_no_valid", it), nvalid, 32'd0);
        check($sformatf("rand%0d_abort_data", it), {16'd0, in_data}, {16'd0, model_data});
      end else begin
        run_in(sw, bounce, sw, $sformatf("rand%0d", it));
      end
      nvalid = 0;
      idle_count($urandom_range(0, 4), nvalid);
    end

    // No press at all
    cu_inReq = 1'b1; confirm_btn = 1'b0;
`ifdef IN_TIMEOUT_EN
    wait_valid(60, seen, stall_bad, ncyc);
    check("tmo_valid", {31'd0, seen}, 32'd1);
    check("tmo_flag", {31'd0, in_timeout}, 32'd1);
    check("tmo_data_zero", {16'd0, in_data}, 32'd0);
    check("tmo_latency", ncyc, 32'd33);
    check("tmo_stalled_before", {31'd0, stall_bad}, 32'd0);
`else
    wait_valid(100, seen, stall_bad, ncyc);
    check("notmo_no_valid", {31'd0, seen}, 32'd0);
    check("notmo_still_stalled", {31'd0, in_stall}, 32'd1);
    check("notmo_stalled_throughout", {31'd0, stall_bad}, 32'd0);
`endif
    cu_inReq = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
